// File: rtl/quad_decoder_if.sv
// Quadrature decoder signal bundle.
// The master side owns the encoder pins and the error-clear strobe; the slave
// side (the decoder) returns the step/dir pair, the error status and a debug
// view of its sequencing state.
// Handshake: step acts as a one-cycle valid qualifier for dir with no ready
// back-pressure; the consumer must take every step pulse in the cycle it is high.
interface quad_decoder_if #(
    parameter int err_cnt_size = 8
);
    logic                    a_in;
    logic                    b_in;
    logic                    clear_err;
    logic                    step;
    logic                    dir;
    logic                    err;
    logic [err_cnt_size-1:0] err_cnt;
    logic                    dbg_state;

    modport master (
        output a_in,
        output b_in,
        output clear_err,
        input  step,
        input  dir,
        input  err,
        input  err_cnt,
        input  dbg_state
    );

    modport slave (
        input  a_in,
        input  b_in,
        input  clear_err,
        output step,
        output dir,
        output err,
        output err_cnt,
        output dbg_state
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature (A/B) encoder front end.
// Synchronises both channels, filters short pulses, then decodes Gray-code
// transitions of the filtered pair into a single-cycle step pulse and a
// direction bit. Two-bit jumps are counted as illegal transitions.
// dbg_state reports the sequencer state: 0 = INIT, 1 = TRACK.
module quad_decoder #(
    parameter int filter_len   = 3,
    parameter int err_cnt_size = 8
) (
    input  logic               clk,
    input  logic               res_n,
    quad_decoder_if.slave      bus
);

    // Filter counter only has to reach filter_len-1 before the accept cycle.
    localparam int CNT_W  = (filter_len > 1) ? $clog2(filter_len) : 1;
    // INIT counter runs 0 .. filter_len+1 inclusive.
    localparam int INIT_W = $clog2(filter_len + 2);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t                  r_state;
    logic [INIT_W-1:0]       r_init_cnt;

    logic                    r_a_meta;
    logic                    r_a_sync;
    logic                    r_b_meta;
    logic                    r_b_sync;

    logic [1:0]              r_filt;
    logic [CNT_W-1:0]        r_fcnt [2];
    logic [1:0]              r_prev;

    logic                    r_step;
    logic                    r_dir;
    logic                    r_err;
    logic [err_cnt_size-1:0] r_err_cnt;

    logic [1:0]              w_sync;
    logic                    w_init_done;
    logic [1:0]              w_delta;
    logic                    w_one_change;
    logic                    w_illegal;

    // Bit 1 carries channel A, bit 0 carries channel B.
    assign w_sync       = {r_a_sync, r_b_sync};
    assign w_init_done  = (r_state == ST_INIT) &&
                          (r_init_cnt == INIT_W'(filter_len + 1));
    assign w_delta      = r_filt ^ r_prev;
    assign w_one_change = (r_state == ST_TRACK) && (w_delta[1] ^ w_delta[0]);
    assign w_illegal    = (r_state == ST_TRACK) && (w_delta == 2'b11);

    // Two-flop synchronisers for the asynchronous encoder pins.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
        end else begin
            r_a_meta <= bus.a_in;
            r_a_sync <= r_a_meta;
            r_b_meta <= bus.b_in;
            r_b_sync <= r_b_meta;
        end
    end

    // Per-channel glitch filter: a new level is taken only after filter_len
    // consecutive differing samples; the INIT exit seeds it with the synced pins.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_filt    <= 2'b00;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else if (r_state == ST_INIT) begin
            if (w_init_done) begin
                r_filt <= w_sync;
            end
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == CNT_W'(filter_len - 1)) begin
                    r_filt[i] <= w_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequencer plus registered decode outputs: settle in INIT, then compare
    // the filtered pair against the previous one every cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_prev     <= 2'b00;
            r_step     <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_step <= 1'b0;
                    if (w_init_done) begin
                        r_prev  <= w_sync;
                        r_state <= ST_TRACK;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_TRACK: begin
                    r_prev <= r_filt;
                    r_step <= w_one_change;
                    // Forward order 00->10->11->01: old A equals new B going
                    // forward, so their XOR is the reverse flag.
                    if (w_one_change) begin
                        r_dir <= r_prev[1] ^ r_filt[0];
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_step  <= 1'b0;
                end
            endcase

            // A fresh illegal jump outranks a simultaneous clear request.
            if (w_illegal) begin
                r_err <= 1'b1;
                if (bus.clear_err) begin
                    r_err_cnt <= err_cnt_size'(1);
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (bus.clear_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
        end
    end

    assign bus.step      = r_step;
    assign bus.dir       = r_dir;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed sections plus a random rotation walk,
// checked cycle by cycle against a position-based model of the encoder.
module tb_quad_decoder;

    localparam int FL      = 3;
    localparam int ECW     = 8;
    localparam int LAT     = FL + 3;
    localparam int MAX_CNT = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic res_n = 1'b0;

    always #5 clk = ~clk;

    quad_decoder_if #(.err_cnt_size(ECW)) bus ();

    quad_decoder #(.filter_len(FL), .err_cnt_size(ECW)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Model state: encoder position on the forward Gray ring, events keyed
    // by the cycle in which the DUT output must show them.
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int   m_pos;
    bit   exp_step  [int];
    bit   exp_dir   [int];
    bit   exp_errev [int];
    bit   clr_at    [int];
    logic m_dir;
    logic m_err;
    int   m_cnt;
    int   m_steps   = 0;
    int   obs_steps = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) tick();
    endtask

    // Move the encoder to ring position np and hold it for 'hold' cycles.
    task automatic move(input int np, input int hold);
        int d;
        int e;
        tick();
        {bus.a_in, bus.b_in} = seq[np];
        d = (np - m_pos + 4) % 4;
        e = cyc + LAT;
        if (d == 1) begin
            exp_step[e] = 1'b1;
            exp_dir[e]  = 1'b0;
        end else if (d == 3) begin
            exp_step[e] = 1'b1;
            exp_dir[e]  = 1'b1;
        end else if (d == 2) begin
            exp_errev[e] = 1'b1;
        end
        m_pos = np;
        repeat (hold - 1) tick();
    endtask

    task automatic model_reset();
        exp_step.delete();
        exp_dir.delete();
        exp_errev.delete();
        clr_at.delete();
        m_dir = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (res_n) begin
            if (exp_step.exists(cyc)) begin
                m_dir = exp_dir[cyc];
                m_steps++;
            end
            if (exp_errev.exists(cyc)) begin
                m_err = 1'b1;
                if (clr_at.exists(cyc)) m_cnt = 1;
                else if (m_cnt < MAX_CNT) m_cnt = m_cnt + 1;
            end else if (clr_at.exists(cyc)) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (bus.step === 1'b1) obs_steps++;
            check("step", bus.step, exp_step.exists(cyc));
            check("dir", bus.dir, m_dir);
            check("err", bus.err, m_err);
            check("err_cnt", bus.err_cnt, m_cnt);
        end
    end

    initial begin
        int e;
        int r;
        int np;

        bus.a_in      = 1'b1;
        bus.b_in      = 1'b1;
        bus.clear_err = 1'b0;
        m_pos         = 2;
        model_reset();

        // Reset values while held in reset.
        repeat (3) tick();
        check("rst_step", bus.step, 1'b0);
        check("rst_dir", bus.dir, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_err_cnt", bus.err_cnt, 0);

        // Release with pins at 11: INIT must not produce step or err.
        res_n = 1'b1;
        repeat (12) tick();
        check("init_steps", obs_steps, 0);
        check("init_err", bus.err, 1'b0);

        // Forward: 11->01->00->10->11.
        move(3, 8);
        move(0, 8);
        move(1, 8);
        move(2, 8);
        repeat (10) tick();
        check("fwd_steps", obs_steps, m_steps);
        check("fwd_count", m_steps, 4);
        check("fwd_dir", bus.dir, 1'b0);

        // Back to 00, then reverse: 00->01->11->10->00.
        move(1, 8);
        move(0, 8);
        move(3, 8);
        move(2, 8);
        move(1, 8);
        move(0, 8);
        repeat (20) tick();
        check("rev_steps", obs_steps, m_steps);
        check("rev_dir_hold", bus.dir, 1'b1);

        // Two-cycle glitch on A is swallowed by the filter.
        tick();
        bus.a_in = 1'b1;
        tick();
        tick();
        bus.a_in = 1'b0;
        repeat (15) tick();
        check("glitch_steps", obs_steps, m_steps);
        check("glitch_err", bus.err, 1'b0);

        // Three-cycle pulse: one forward step and one reverse step.
        move(1, 3);
        move(0, 8);
        repeat (10) tick();
        check("pulse_steps", obs_steps, m_steps);
        check("pulse_dir", bus.dir, 1'b1);

        // Single illegal jump 00->11.
        move(2, 8);
        repeat (10) tick();
        check("jump_err", bus.err, 1'b1);
        check("jump_cnt", bus.err_cnt, 1);
        check("jump_steps", obs_steps, m_steps);

        // 300 more illegal jumps saturate the counter.
        for (int i = 0; i < 300; i++) move((m_pos + 2) % 4, 5);
        repeat (10) tick();
        check("sat_cnt", bus.err_cnt, MAX_CNT);
        check("sat_err", bus.err, 1'b1);

        // Plain clear.
        tick();
        bus.clear_err = 1'b1;
        clr_at[cyc + 1] = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        tick();
        check("clr_err", bus.err, 1'b0);
        check("clr_cnt", bus.err_cnt, 0);

        // Clear landing in the same cycle as a new illegal jump.
        move((m_pos + 2) % 4, 1);
        e = cyc + LAT;
        goto_cycle(e - 1);
        bus.clear_err = 1'b1;
        clr_at[e] = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        repeat (8) tick();
        check("clr_vs_err_err", bus.err, 1'b1);
        check("clr_vs_err_cnt", bus.err_cnt, 1);

        // Reset asserted while a reverse step pulse is on the output.
        move((m_pos + 3) % 4, 1);
        e = cyc + LAT;
        goto_cycle(e);
        check("pre_rst_step", bus.step, 1'b1);
        res_n = 1'b0;
        #1;
        check("mid_rst_step", bus.step, 1'b0);
        check("mid_rst_dir", bus.dir, 1'b0);
        check("mid_rst_err", bus.err, 1'b0);
        check("mid_rst_cnt", bus.err_cnt, 0);
        model_reset();
        repeat (3) tick();
        res_n = 1'b1;
        repeat (12) tick();
        check("rerst_steps", obs_steps, m_steps);

        // Random walk: mostly legal moves with occasional illegal jumps.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) np = (m_pos + 2) % 4;
            else if (r <= 5) np = (m_pos + 1) % 4;
            else np = (m_pos + 3) % 4;
            move(np, $urandom_range(FL + 1, 9));
        end
        repeat (15) tick();
        check("rand_steps", obs_steps, m_steps);
        check("rand_cnt", bus.err_cnt, m_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
